// File: rtl/usb_tx_arb_pkg.sv
// Shared types and defaults for the usb_tx packet arbiter.
// Holds the FSM state enum, the default timing constants and small sizing helpers.
package usb_tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    GAP    = 3'd4
  } arbState_e;

  localparam int DEFAULT_NUM_REQ        = 3;
  localparam int DEFAULT_MIN_GAP_CYCLES = 16;
  localparam int DEFAULT_START_TIMEOUT  = 256;

  // One shared counter serves both the gap and the start timeout, so size it for the larger limit.
  function automatic int cntWidth(input int gapCycles, input int timeout);
    int limit;
    limit = (gapCycles > timeout) ? gapCycles : timeout;
    return $clog2(limit + 1);
  endfunction

  function automatic int nextIdx(input int idx, input int numReq);
    return (idx + 1 >= numReq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/usb_tx_arbiter_if.sv
// Byte-stream link between the arbiter (master) and the usb_tx serialiser (slave).
interface usb_tx_arbiter_if;

  logic       txReqSendPacket;
  logic       txAcceptNewData;
  logic       txIsLastByte;
  logic       txDataValid;
  logic [7:0] txData;
  logic       sending;

  modport master (
    output txReqSendPacket,
    output txIsLastByte,
    output txDataValid,
    output txData,
    input  txAcceptNewData,
    input  sending
  );

  modport slave (
    input  txReqSendPacket,
    input  txIsLastByte,
    input  txDataValid,
    input  txData,
    output txAcceptNewData,
    output sending
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to bit 0.
// Returns the winner both one-hot and as a binary index.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grantIdx,
  output logic               anyReq
);

  logic [NUM_REQ-1:0] atOrAbovePtr;
  logic [NUM_REQ-1:0] maskedReq;
  logic [NUM_REQ-1:0] maskedFirst;
  logic [NUM_REQ-1:0] plainFirst;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : gMask
    assign atOrAbovePtr[gi] = (gi >= int'(ptr));
  end

  // x & -x isolates the lowest set bit; the unmasked vector covers the wrap-around case.
  assign maskedReq   = req & atOrAbovePtr;
  assign maskedFirst = maskedReq & (~maskedReq + NUM_REQ'(1));
  assign plainFirst  = req & (~req + NUM_REQ'(1));
  assign grant       = (|maskedReq) ? maskedFirst : plainFirst;
  assign anyReq      = |req;

  always_comb begin
    grantIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grantIdx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Shares one usb_tx byte stream between NUM_REQ packet sources, round-robin per whole packet,
// with an enforced inter-packet gap and an abort when the frontend never starts sending.
module usb_tx_arbiter
  import usb_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int MIN_GAP_CYCLES = DEFAULT_MIN_GAP_CYCLES,
  parameter int START_TIMEOUT  = DEFAULT_START_TIMEOUT
) (
  input  logic                   clk48,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     reqSendPacket,
  output logic [NUM_REQ-1:0]     reqGrant,
  output logic [NUM_REQ-1:0]     reqAcceptNewData,
  input  logic [NUM_REQ-1:0]     reqIsLastByte,
  input  logic [NUM_REQ-1:0]     reqDataValid,
  input  logic [8*NUM_REQ-1:0]   reqData,
  usb_tx_arbiter_if.master       tx,
  output logic                   busy,
  output logic                   startTimeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cntWidth(MIN_GAP_CYCLES, START_TIMEOUT);

  arbState_e          stateReg, stateNext;
  logic [NUM_REQ-1:0] grantReg, grantNext;
  logic [IDX_W-1:0]   gIdxReg, gIdxNext;
  logic [IDX_W-1:0]   rrPtrReg, rrPtrNext;
  logic [CNT_W-1:0]   cntReg, cntNext;
  logic               timeoutReg, timeoutNext;

  logic [NUM_REQ-1:0] arbGrant;
  logic [IDX_W-1:0]   arbIdx;
  logic               anyReq;

  logic [7:0]         reqByte [NUM_REQ];
  logic [7:0]         selData;
  logic               selValid;
  logic               selLast;
  logic               handshake;
  logic               streamOut;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) arb (
    .req      (reqSendPacket),
    .ptr      (rrPtrReg),
    .grant    (arbGrant),
    .grantIdx (arbIdx),
    .anyReq   (anyReq)
  );

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : gLane
    assign reqByte[gi]          = reqData[8*gi +: 8];
    assign reqAcceptNewData[gi] = streamOut && grantReg[gi] && tx.txAcceptNewData;
  end

  assign selData   = reqByte[gIdxReg];
  assign selValid  = reqDataValid[gIdxReg];
  assign selLast   = reqIsLastByte[gIdxReg];
  assign handshake = tx.txAcceptNewData && selValid;

  // RST gates the stream combinationally so a reset mid-packet stops tx* in the same cycle.
  assign streamOut          = (stateReg == STREAM) && !RST;
  assign tx.txReqSendPacket = (stateReg == ARM) && !RST;
  assign tx.txDataValid     = streamOut && selValid;
  assign tx.txIsLastByte    = streamOut && selLast;
  assign tx.txData          = streamOut ? selData : 8'h00;

  assign reqGrant     = grantReg;
  assign busy         = (stateReg != IDLE);
  assign startTimeout = timeoutReg;

  always_comb begin
    stateNext   = stateReg;
    grantNext   = grantReg;
    gIdxNext    = gIdxReg;
    rrPtrNext   = rrPtrReg;
    cntNext     = cntReg;
    timeoutNext = 1'b0;
    case (stateReg)
      IDLE: begin
        if (anyReq) begin
          grantNext = arbGrant;
          gIdxNext  = arbIdx;
          cntNext   = '0;
          stateNext = ARM;
        end
      end
      ARM: begin
        if (tx.sending) begin
          cntNext   = '0;
          stateNext = STREAM;
        end else if (cntReg >= CNT_W'(START_TIMEOUT - 1)) begin
          // Pointer is left alone so the same source gets another attempt.
          timeoutNext = 1'b1;
          grantNext   = '0;
          cntNext     = '0;
          stateNext   = GAP;
        end else begin
          cntNext = cntReg + CNT_W'(1);
        end
      end
      STREAM: begin
        if (handshake && selLast) begin
          stateNext = DRAIN;
        end else if (!tx.sending) begin
          grantNext = '0;
          rrPtrNext = IDX_W'(nextIdx(int'(gIdxReg), NUM_REQ));
          cntNext   = '0;
          stateNext = GAP;
        end
      end
      DRAIN: begin
        if (!tx.sending) begin
          grantNext = '0;
          rrPtrNext = IDX_W'(nextIdx(int'(gIdxReg), NUM_REQ));
          cntNext   = '0;
          stateNext = GAP;
        end
      end
      GAP: begin
        if (cntReg >= CNT_W'(MIN_GAP_CYCLES - 1)) begin
          cntNext   = '0;
          stateNext = IDLE;
        end else begin
          cntNext = cntReg + CNT_W'(1);
        end
      end
      default: begin
        grantNext = '0;
        cntNext   = '0;
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk48) begin
    if (RST) begin
      stateReg   <= IDLE;
      grantReg   <= '0;
      gIdxReg    <= '0;
      rrPtrReg   <= '0;
      cntReg     <= '0;
      timeoutReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      grantReg   <= grantNext;
      gIdxReg    <= gIdxNext;
      rrPtrReg   <= rrPtrNext;
      cntReg     <= cntNext;
      timeoutReg <= timeoutNext;
    end
  end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter: the bench plays both the packet sources and the usb_tx frontend.
module tb_usb_tx_arbiter;

  localparam int NREQ    = 3;
  localparam int MIN_GAP = 16;
  localparam int TMO     = 256;

  logic        clk48 = 1'b0;
  logic        RST   = 1'b1;
  logic [2:0]  reqSendPacket = '0;
  logic [2:0]  reqIsLastByte = '0;
  logic [2:0]  reqDataValid  = '0;
  logic [23:0] reqData       = '0;
  logic [2:0]  reqGrant;
  logic [2:0]  reqAcceptNewData;
  logic        busy;
  logic        startTimeout;

  int nAssert = 0;
  int nFail   = 0;

  logic [7:0] bpByte [3] = '{8'hA1, 8'hA2, 8'hA3};
  logic [2:0] ordGrant [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [7:0] ordByte  [4] = '{8'h11, 8'h22, 8'h33, 8'h11};

  usb_tx_arbiter_if txBus();

  usb_tx_arbiter #(
    .NUM_REQ        (NREQ),
    .MIN_GAP_CYCLES (MIN_GAP),
    .START_TIMEOUT  (TMO)
  ) dut (
    .clk48            (clk48),
    .RST              (RST),
    .reqSendPacket    (reqSendPacket),
    .reqGrant         (reqGrant),
    .reqAcceptNewData (reqAcceptNewData),
    .reqIsLastByte    (reqIsLastByte),
    .reqDataValid     (reqDataValid),
    .reqData          (reqData),
    .tx               (txBus),
    .busy             (busy),
    .startTimeout     (startTimeout)
  );

  always #5 clk48 = ~clk48;

  task automatic step();
    @(posedge clk48);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitGrant(input string tag, input logic [2:0] exp);
    int k = 0;
    while (reqGrant === 3'b000 && k < 60) begin
      step();
      k++;
    end
    #1;
    chk(tag, reqGrant, exp);
  endtask

  // Called in the first ARM cycle; grantee must present a valid last byte.
  task automatic runOneByte(input string tag, input logic [2:0] g, input logic [7:0] b);
    txBus.sending = 1'b1;
    step();
    txBus.txAcceptNewData = 1'b1;
    #1;
    chk($sformatf("%s data", tag), txBus.txData, b);
    chk($sformatf("%s last", tag), txBus.txIsLastByte, 1);
    chk($sformatf("%s acc", tag), reqAcceptNewData, g);
    step();
    txBus.txAcceptNewData = 1'b0;
    txBus.sending = 1'b0;
    #1;
    chk($sformatf("%s drain dv", tag), txBus.txDataValid, 0);
    step();
    #1;
    chk($sformatf("%s gap grant", tag), reqGrant, 0);
  endtask

  initial begin
    txBus.sending = 1'b0;
    txBus.txAcceptNewData = 1'b0;

    // Reset state
    step();
    step();
    #1;
    chk("rst grant", reqGrant, 0);
    chk("rst busy", busy, 0);
    chk("rst txReq", txBus.txReqSendPacket, 0);
    chk("rst tmo", startTimeout, 0);
    chk("rst dv", txBus.txDataValid, 0);
    RST = 1'b0;

    // Single packet from requester 1, then requester 0 re-requests during the gap
    step();
    reqSendPacket = 3'b010;
    reqDataValid  = 3'b010;
    reqData       = 24'h00C300;
    #1;
    chk("t1 no grant yet", reqGrant, 0);
    step();
    #1;
    chk("t1 grant", reqGrant, 3'b010);
    chk("t1 txReq", txBus.txReqSendPacket, 1);
    chk("t1 arm dv", txBus.txDataValid, 0);
    reqSendPacket = 3'b000;
    txBus.sending = 1'b1;
    step();
    #1;
    chk("t1 txReq off", txBus.txReqSendPacket, 0);
    chk("t1 byte0", txBus.txData, 8'hC3);
    chk("t1 dv", txBus.txDataValid, 1);
    chk("t1 acc idle", reqAcceptNewData, 0);
    txBus.txAcceptNewData = 1'b1;
    #1;
    chk("t1 acc", reqAcceptNewData, 3'b010);
    step();
    reqData = 24'h001100;
    #1;
    chk("t1 byte1", txBus.txData, 8'h11);
    chk("t1 byte1 last", txBus.txIsLastByte, 0);
    step();
    reqData = 24'h002200;
    reqIsLastByte = 3'b010;
    #1;
    chk("t1 byte2", txBus.txData, 8'h22);
    chk("t1 byte2 last", txBus.txIsLastByte, 1);
    step();
    txBus.txAcceptNewData = 1'b0;
    reqDataValid  = 3'b000;
    reqIsLastByte = 3'b000;
    #1;
    chk("t1 drain dv", txBus.txDataValid, 0);
    chk("t1 drain grant", reqGrant, 3'b010);
    chk("t1 drain busy", busy, 1);
    txBus.sending = 1'b0;
    step();
    reqSendPacket = 3'b001;
    reqDataValid  = 3'b001;
    reqIsLastByte = 3'b001;
    reqData       = 24'h00005A;
    #1;
    chk("t1 gap grant", reqGrant, 0);
    chk("t1 gap busy", busy, 1);
    repeat (15) step();
    #1;
    chk("t1 busy at gap end", busy, 1);
    step();
    #1;
    chk("t1 busy low", busy, 0);
    chk("t6 no txReq yet", txBus.txReqSendPacket, 0);
    step();
    #1;
    chk("t6 txReq", txBus.txReqSendPacket, 1);
    chk("t6 grant", reqGrant, 3'b001);
    reqSendPacket = 3'b000;
    runOneByte("t6 pkt", 3'b001, 8'h5A);

    // Start timeout: rrPtr=1, requesters 1 and 2 pending
    reqSendPacket = 3'b110;
    reqDataValid  = 3'b000;
    reqIsLastByte = 3'b000;
    waitGrant("t4 grant", 3'b010);
    repeat (255) step();
    #1;
    chk("t4 still arm", txBus.txReqSendPacket, 1);
    chk("t4 no tmo early", startTimeout, 0);
    step();
    #1;
    chk("t4 tmo pulse", startTimeout, 1);
    chk("t4 tmo grant", reqGrant, 0);
    chk("t4 tmo txReq", txBus.txReqSendPacket, 0);
    chk("t4 tmo busy", busy, 1);
    step();
    #1;
    chk("t4 tmo one cycle", startTimeout, 0);
    waitGrant("t4 regrant", 3'b010);
    reqSendPacket = 3'b100;
    reqDataValid  = 3'b010;
    reqIsLastByte = 3'b010;
    reqData       = 24'h007700;
    runOneByte("t4 pkt", 3'b010, 8'h77);

    // Backpressure: requester 2 toggles valid every other cycle
    reqDataValid  = 3'b000;
    reqIsLastByte = 3'b000;
    waitGrant("t3 grant", 3'b100);
    reqSendPacket = 3'b000;
    txBus.sending = 1'b1;
    txBus.txAcceptNewData = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      reqDataValid  = {i[0], 2'b00};
      reqIsLastByte = {(i == 5), 2'b00};
      reqData       = {bpByte[i / 2], 16'h0000};
      #1;
      chk($sformatf("t3 acc c%0d", i), reqAcceptNewData, 3'b100);
      chk($sformatf("t3 dv c%0d", i), txBus.txDataValid, i % 2);
      if (i % 2 == 1) begin
        chk($sformatf("t3 data c%0d", i), txBus.txData, bpByte[i / 2]);
      end
      step();
    end
    txBus.txAcceptNewData = 1'b0;
    #1;
    chk("t3 drain data", txBus.txData, 0);
    chk("t3 drain dv", txBus.txDataValid, 0);
    chk("t3 drain grant", reqGrant, 3'b100);
    chk("t3 drain acc", reqAcceptNewData, 0);
    reqDataValid  = 3'b000;
    reqIsLastByte = 3'b000;
    txBus.sending = 1'b0;
    step();

    // Contention: all three held, rrPtr=0
    reqSendPacket = 3'b111;
    reqDataValid  = 3'b111;
    reqIsLastByte = 3'b111;
    reqData       = 24'h332211;
    for (int i = 0; i < 4; i++) begin
      waitGrant($sformatf("t2 grant%0d", i), ordGrant[i]);
      runOneByte($sformatf("t2 pkt%0d", i), ordGrant[i], ordByte[i]);
    end
    reqSendPacket = 3'b000;

    // Reset in the middle of a 5-byte packet from requester 1 (rrPtr=1 beforehand)
    reqSendPacket = 3'b010;
    reqDataValid  = 3'b010;
    reqIsLastByte = 3'b000;
    reqData       = 24'h00B100;
    waitGrant("t5 grant", 3'b010);
    txBus.sending = 1'b1;
    step();
    txBus.txAcceptNewData = 1'b1;
    step();
    reqData = 24'h00B200;
    step();
    reqData = 24'h00B300;
    #1;
    chk("t5 byte3 shown", txBus.txData, 8'hB3);
    RST = 1'b1;
    #1;
    chk("t5 rst dv", txBus.txDataValid, 0);
    chk("t5 rst txData", txBus.txData, 0);
    chk("t5 rst acc", reqAcceptNewData, 0);
    step();
    #1;
    chk("t5 rst grant", reqGrant, 0);
    chk("t5 rst busy", busy, 0);
    chk("t5 rst txReq", txBus.txReqSendPacket, 0);
    RST = 1'b0;
    txBus.sending = 1'b0;
    txBus.txAcceptNewData = 1'b0;
    reqDataValid  = 3'b000;
    reqSendPacket = 3'b111;
    waitGrant("t5 rrPtr cleared", 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
